// File: rtl/reg_wb_pkg.sv
// Shared types for the register writeback stage: widths, the buffered MEM entry,
// and the scoreboard lookup helper.
package reg_wb_pkg;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int NREGS  = 1 << REG_AW;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_entry_t;

   // x0 is never pending, whatever the scoreboard holds
   function automatic logic reg_busy(input logic [NREGS-1:0] p, input logic [REG_AW-1:0] r);
      return (r != '0) && p[r];
   endfunction
endpackage

// File: rtl/wb_fifo.sv
// Small in-order buffer for memory-path results; no pass-through, so a push into
// an empty buffer is visible at the head one cycle later.
module wb_fifo
   import reg_wb_pkg::*;
#(
   parameter int  FIFO_DEPTH = 2,
   parameter type T          = wb_entry_t
) (
   input  logic CLK,
   input  logic RST,
   input  logic push,
   input  T     din,
   input  logic pop,
   output T     dout,
   output logic full,
   output logic empty
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   T              mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic          do_push, do_pop;

   assign full    = (count == CW'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rptr];

   // power-of-two depth lets the pointers wrap by plain overflow
   always_ff @(posedge CLK) begin
      if (RST) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem[wptr] <= din;
   end
endmodule

// File: rtl/reg_writeback.sv
// Register-file writeback arbiter: ALU results win, MEM results queue in wb_fifo,
// and a pending scoreboard stalls issue on outstanding long-latency rds.
// Define WB_BYPASS_EN to add FWD_* outputs and clear pending on the select edge.
module reg_writeback
   import reg_wb_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ALU_V,
   input  logic [REG_AW-1:0] ALU_RD,
   input  logic [XLEN-1:0]   ALU_D,
   input  logic              MEM_V,
   input  logic [REG_AW-1:0] MEM_RD,
   input  logic [XLEN-1:0]   MEM_D,
   output logic              MEM_RDY,
   input  logic              ISS_V,
   input  logic              ISS_LONG,
   input  logic [REG_AW-1:0] ISS_RD,
   input  logic [REG_AW-1:0] ISS_RS1,
   input  logic [REG_AW-1:0] ISS_RS2,
   output logic              STALL,
   output logic              RF_WE,
   output logic [REG_AW-1:0] RF_AW,
   output logic [XLEN-1:0]   RF_D
`ifdef WB_BYPASS_EN
   ,
   output logic              FWD_V,
   output logic [REG_AW-1:0] FWD_RD,
   output logic [XLEN-1:0]   FWD_D
`endif
);
   wb_entry_t         head, mem_in;
   logic              full, empty, alu_sel, push, pop;
   logic [NREGS-1:0]  pending, set_m, clr_m;
   logic              clr_v;
   logic [REG_AW-1:0] clr_rd;

   assign alu_sel = ALU_V & (ALU_RD != '0);
   assign MEM_RDY = ~RST & ~full;
   assign push    = MEM_V & MEM_RDY & (MEM_RD != '0);
   assign pop     = ~RST & ~alu_sel & ~empty;
   assign mem_in  = '{rd: MEM_RD, data: MEM_D};

   wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .T(wb_entry_t)) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (push),
      .din   (mem_in),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   assign STALL = ~RST & ISS_V &
                  (reg_busy(pending, ISS_RS1) | reg_busy(pending, ISS_RS2) |
                   reg_busy(pending, ISS_RD));

`ifdef WB_BYPASS_EN
   // forwarding covers the consumer, so the bit can drop as the entry is selected
   assign clr_v  = pop;
   assign clr_rd = head.rd;
   assign FWD_V  = RF_WE;
   assign FWD_RD = RF_AW;
   assign FWD_D  = RF_D;
`else
   // hold the bit one edge past RF_WE so the registered RF read sees the new value
   always_ff @(posedge CLK) begin
      if (RST) begin
         clr_v  <= 1'b0;
         clr_rd <= '0;
      end else begin
         clr_v  <= pop;
         clr_rd <= head.rd;
      end
   end
`endif

   assign clr_m = NREGS'(clr_v) << clr_rd;
   assign set_m = NREGS'(ISS_V & ISS_LONG & ~STALL & (ISS_RD != '0)) << ISS_RD;

   always_ff @(posedge CLK) begin
      if (RST) pending <= '0;
      else     pending <= ((pending & ~clr_m) | set_m) & {{(NREGS-1){1'b1}}, 1'b0};
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         RF_WE <= 1'b0;
         RF_AW <= '0;
         RF_D  <= '0;
      end else begin
         RF_WE <= alu_sel | pop;
         if (alu_sel) begin
            RF_AW <= ALU_RD;
            RF_D  <= ALU_D;
         end else if (pop) begin
            RF_AW <= head.rd;
            RF_D  <= head.data;
         end else begin
            RF_AW <= '0;
            RF_D  <= '0;
         end
      end
   end
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback with hand-computed expectations (FIFO_DEPTH=2).
module tb_reg_writeback;
   logic        CLK = 1'b0;
   logic        RST;
   logic        ALU_V, MEM_V, ISS_V, ISS_LONG;
   logic [4:0]  ALU_RD, MEM_RD, ISS_RD, ISS_RS1, ISS_RS2;
   logic [31:0] ALU_D, MEM_D;
   logic        MEM_RDY, STALL, RF_WE;
   logic [4:0]  RF_AW;
   logic [31:0] RF_D;
`ifdef WB_BYPASS_EN
   logic        FWD_V;
   logic [4:0]  FWD_RD;
   logic [31:0] FWD_D;
`endif
   int checks = 0;
   int errors = 0;

   reg_writeback #(.FIFO_DEPTH(2)) dut (
      .CLK(CLK), .RST(RST),
      .ALU_V(ALU_V), .ALU_RD(ALU_RD), .ALU_D(ALU_D),
      .MEM_V(MEM_V), .MEM_RD(MEM_RD), .MEM_D(MEM_D), .MEM_RDY(MEM_RDY),
      .ISS_V(ISS_V), .ISS_LONG(ISS_LONG), .ISS_RD(ISS_RD),
      .ISS_RS1(ISS_RS1), .ISS_RS2(ISS_RS2), .STALL(STALL),
      .RF_WE(RF_WE), .RF_AW(RF_AW), .RF_D(RF_D)
`ifdef WB_BYPASS_EN
      , .FWD_V(FWD_V), .FWD_RD(FWD_RD), .FWD_D(FWD_D)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      ALU_V = 0; ALU_RD = 0; ALU_D = 0;
      MEM_V = 0; MEM_RD = 0; MEM_D = 0;
      ISS_V = 0; ISS_LONG = 0; ISS_RD = 0; ISS_RS1 = 0; ISS_RS2 = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      RST = 1;
      ISS_V = 1; ISS_RS1 = 4;
      tick(); tick();
      chk("rst_we", RF_WE, 0);
      chk("rst_aw", RF_AW, 0);
      chk("rst_d", RF_D, 0);
      chk("rst_rdy", MEM_RDY, 0);
      chk("rst_stall", STALL, 0);
      idle();
      RST = 0;
      #1;
      chk("post_rst_rdy", MEM_RDY, 1);

      // single ALU write
      ALU_V = 1; ALU_RD = 5; ALU_D = 32'hDEADBEEF;
      tick();
      ALU_V = 0;
      chk("alu_we", RF_WE, 1);
      chk("alu_aw", RF_AW, 5);
      chk("alu_d", RF_D, 32'hDEADBEEF);
      tick();
      chk("alu_we_off", RF_WE, 0);

      // ALU priority over a queued MEM result
      ALU_V = 1; ALU_RD = 7; ALU_D = 32'h77;
      MEM_V = 1; MEM_RD = 3; MEM_D = 32'h11;
      tick();
      MEM_V = 0;
      chk("pri_aw0", RF_AW, 7);
      tick();
      ALU_V = 0;
      chk("pri_aw1", RF_AW, 7);
      chk("pri_d1", RF_D, 32'h77);
      tick();
      chk("pri_mem_we", RF_WE, 1);
      chk("pri_mem_aw", RF_AW, 3);
      chk("pri_mem_d", RF_D, 32'h11);
      tick();
      chk("pri_idle_we", RF_WE, 0);

      // fill to full, third push held, order preserved
      ALU_V = 1; ALU_RD = 1; ALU_D = 32'hA0;
      MEM_V = 1; MEM_RD = 10; MEM_D = 32'h1;
      tick();
      MEM_RD = 11; MEM_D = 32'h2;
      chk("fill_rdy1", MEM_RDY, 1);
      tick();
      MEM_RD = 12; MEM_D = 32'h3;
      chk("full_rdy", MEM_RDY, 0);
      tick();
      chk("full_hold_rdy", MEM_RDY, 0);
      ALU_V = 0;
      tick();
      chk("ord1_aw", RF_AW, 10);
      chk("ord1_d", RF_D, 1);
      chk("ord_rdy", MEM_RDY, 1);
      tick();
      MEM_V = 0;
      chk("ord2_aw", RF_AW, 11);
      chk("ord2_d", RF_D, 2);
      tick();
      chk("ord3_aw", RF_AW, 12);
      chk("ord3_d", RF_D, 3);
      tick();
      chk("ord_done_we", RF_WE, 0);

      // rd=0 results are dropped on both paths
      ALU_V = 1; ALU_RD = 0; ALU_D = 32'h55;
      MEM_V = 1; MEM_RD = 0; MEM_D = 32'h66;
      #1;
      chk("x0_rdy", MEM_RDY, 1);
      tick();
      MEM_V = 0;
      chk("x0_we0", RF_WE, 0);
      ALU_V = 0;
      tick();
      chk("x0_we1", RF_WE, 0);
      chk("x0_rdy_after", MEM_RDY, 1);

      // scoreboard stall on long rd 9
      ISS_V = 1; ISS_LONG = 1; ISS_RD = 9;
      #1;
      chk("iss_nostall", STALL, 0);
      tick();
      ISS_LONG = 0; ISS_RD = 0; ISS_RS1 = 9;
      #1;
      chk("dep_stall", STALL, 1);
      ISS_RS1 = 0;
      #1;
      chk("rs0_nostall", STALL, 0);
      ISS_RS2 = 9;
      #1;
      chk("rs2_stall", STALL, 1);
      ISS_RS2 = 0; ISS_RS1 = 9;
      MEM_V = 1; MEM_RD = 9; MEM_D = 32'h99;
      tick();
      MEM_V = 0;
      chk("dep_stall_q", STALL, 1);
      tick();
      chk("dep_wr_aw", RF_AW, 9);
      chk("dep_wr_d", RF_D, 32'h99);
`ifdef WB_BYPASS_EN
      chk("dep_stall_wr", STALL, 0);
      chk("fwd_v", FWD_V, 1);
      chk("fwd_rd", FWD_RD, 9);
`else
      chk("dep_stall_wr", STALL, 1);
`endif
      tick();
      chk("dep_released", STALL, 0);
      idle();
      tick();

      // reset mid-operation
      ALU_V = 1; ALU_RD = 2; ALU_D = 32'h22;
      ISS_V = 1; ISS_LONG = 1; ISS_RD = 4;
      tick();
      ISS_V = 0; ISS_LONG = 0; ISS_RD = 0;
      MEM_V = 1; MEM_RD = 5; MEM_D = 32'h5;
      tick();
      MEM_RD = 6; MEM_D = 32'h6;
      tick();
      MEM_V = 0;
      chk("pre_rst_full", MEM_RDY, 0);
      ISS_V = 1; ISS_RS1 = 4;
      #1;
      chk("pre_rst_stall", STALL, 1);
      RST = 1;
      #1;
      chk("in_rst_stall", STALL, 0);
      chk("in_rst_rdy", MEM_RDY, 0);
      tick();
      chk("in_rst_we", RF_WE, 0);
      RST = 0; ALU_V = 0;
      #1;
      chk("rel_we", RF_WE, 0);
      chk("rel_rdy", MEM_RDY, 1);
      chk("rel_stall", STALL, 0);
      tick();
      chk("rel_fifo_empty_we", RF_WE, 0);
      chk("rel_stall2", STALL, 0);
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, memory-response buffer entries (power of two, >=2).
REQ-002 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports ALU_V in 1, ALU_RD in 5, ALU_D in 32: single-cycle result; always accepted, no backpressure.
REQ-005 SHALL have ports MEM_V in 1, MEM_RD in 5, MEM_D in 32: load/long-latency result, valid/ready handshake.
REQ-006 SHALL have port MEM_RDY  out  1  buffer can accept; transfer occurs when MEM_V & MEM_RDY.
REQ-007 SHALL have ports ISS_V in 1, ISS_LONG in 1, ISS_RD in 5, ISS_RS1 in 5, ISS_RS2 in 5: instruction being issued; ISS_LONG means rd is later written via MEM path.
REQ-008 SHALL have port STALL  out  1  combinational; issue must hold while high.
REQ-009 SHALL have ports RF_WE out 1, RF_AW out 5, RF_D out 32: registered, drive register-file WE/AW/D.

Function
REQ-010 SHALL register writes: a result selected in cycle N appears on RF_WE/RF_AW/RF_D in cycle N+1, for exactly one cycle.
REQ-011 SHALL give ALU priority: ALU_V with ALU_RD!=0 selects the ALU result; otherwise FIFO head is selected and dequeued if non-empty; else RF_WE=0.
REQ-012 SHALL drop results with rd=0: ALU_RD=0 is ignored; MEM_RD=0 is accepted and discarded without entering the FIFO.
REQ-013 SHALL drive MEM_RDY = (count < FIFO_DEPTH); no pass-through when full, even if a dequeue occurs that cycle.
REQ-014 SHALL preserve MEM arrival order; simultaneous enqueue and dequeue keeps count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-015 SHALL hold a 32-bit pending scoreboard; bit 0 is constant 0.
REQ-016 SHALL set pending[ISS_RD] on ISS_V & ISS_LONG & !STALL & ISS_RD!=0.
REQ-017 SHALL clear pending[rd] when that MEM entry's write completes (timing per REQ-024/025); a same-cycle set for the same rd wins.
REQ-018 SHALL assert STALL when ISS_V and any nonzero of ISS_RS1/ISS_RS2/ISS_RD has its pending bit set.
REQ-019 SHALL not stall for ALU-path dependencies; operand timing for those is the issue logic's responsibility.

Reset
REQ-020 SHALL, while RST high: RF_WE=0, RF_AW=0, RF_D=0, MEM_RDY=0, STALL=0, pending all 0, FIFO empty.
REQ-021 SHALL discard buffered MEM entries and in-flight selections on reset mid-operation; no RF write in the cycle after RST deasserts.
REQ-022 SHALL present MEM_RDY=1 in the first cycle after RST deasserts.

Configuration
REQ-023 SHALL compile forwarding under macro WB_BYPASS_EN.
REQ-024 With WB_BYPASS_EN: outputs FWD_V out 1, FWD_RD out 5, FWD_D out 32 equal RF_WE/RF_AW/RF_D; pending cleared on the edge the MEM entry is selected.
REQ-025 Without WB_BYPASS_EN: FWD ports absent; pending cleared one edge after RF_WE presents the write, covering the register file's registered read.

Structure
REQ-026 SHALL take XLEN=32, REG_AW=5 and struct wb_entry_t {rd[4:0], data[31:0]} from shared package reg_wb_pkg.
REQ-027 SHALL implement the buffer as sub-module wb_fifo (params FIFO_DEPTH, entry type wb_entry_t; push/pop/full/empty).

Verification
REQ-028 ALU_V=1, RD=5, D=0xDEADBEEF at cycle 0 -> cycle 1: RF_WE=1, RF_AW=5, RF_D=0xDEADBEEF; cycle 2: RF_WE=0.
REQ-029 MEM push RD=3 D=0x11 while ALU_V=1 RD=7 for 2 cycles -> RD 7 written twice, then RD 3=0x11 in the cycle after ALU idle.
REQ-030 Three MEM pushes back-to-back with ALU_V held 1 -> MEM_RDY=0 after the 2nd; the 3rd holds until a dequeue; order 1,2,3 preserved.
REQ-031 Issue LONG RD=9, then ISS_RS1=9 -> STALL=1 until the RD 9 MEM write; deassert at REQ-024/025 timing; ISS_RS1=0 never stalls.
REQ-032 ALU_V=1 RD=0; MEM RD=0 -> RF_WE stays 0, FIFO count unchanged.
REQ-033 RST asserted with 2 FIFO entries and pending[4]=1 -> after release: no RF write, STALL=0 for RS1=4, MEM_RDY=1.
